// File: rtl/traffic_light_ctrl.sv
// T-junction traffic light sequencer: six-phase Moore FSM with a per-state dwell counter.
// Lamp outputs are a pure decode of the state register, so the counter never reaches them.
module traffic_light_ctrl #(
    parameter int unsigned T_MAIN  = 7,
    parameter int unsigned T_M2Y   = 2,
    parameter int unsigned T_TURN  = 5,
    parameter int unsigned T_TURNY = 2,
    parameter int unsigned T_SIDE  = 3,
    parameter int unsigned T_SIDEY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_M1,
    output logic [2:0] light_S,
    output logic [2:0] light_MT,
    output logic [2:0] light_M2
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   dwell_last;
    state_e             state_nxt;

    // State and dwell counter; reset lands in S1 with a cleared count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance when the count reaches the current state's last cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        dwell_last = '0;
        state_nxt  = S1;
        case (state_q)
            S1: begin dwell_last = CNT_W'(T_MAIN  - 1); state_nxt = S2; end
            S2: begin dwell_last = CNT_W'(T_M2Y   - 1); state_nxt = S3; end
            S3: begin dwell_last = CNT_W'(T_TURN  - 1); state_nxt = S4; end
            S4: begin dwell_last = CNT_W'(T_TURNY - 1); state_nxt = S5; end
            S5: begin dwell_last = CNT_W'(T_SIDE  - 1); state_nxt = S6; end
            S6: begin dwell_last = CNT_W'(T_SIDEY - 1); state_nxt = S1; end
            default: begin dwell_last = '0; state_nxt = S1; end
        endcase
        if (cnt_q == dwell_last) begin
            state_d = state_nxt;
            cnt_d   = '0;
        end
        // Unused encodings fall straight back to S1.
        if (state_q > S6) begin
            state_d = S1;
            cnt_d   = '0;
        end
    end

    // Lamp decode; anything not listed stays red.
    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        case (state_q)
            S1: begin light_M1 = GREEN;  light_M2 = GREEN;  end
            S2: begin light_M1 = GREEN;  light_M2 = YELLOW; end
            S3: begin light_M1 = GREEN;  light_MT = GREEN;  end
            S4: begin light_M1 = YELLOW; light_MT = YELLOW; end
            S5: begin light_S  = GREEN;  end
            S6: begin light_S  = YELLOW; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default timing and a T_MAIN=3/T_SIDE=1 variant,
// checking lamp sequence, async reset behaviour and safety invariants.
module tb_traffic_light_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Packed as {M1, M2, MT, S}
    localparam logic [11:0] P_S1 = {G, G, R, R};
    localparam logic [11:0] P_S2 = {G, Y, R, R};
    localparam logic [11:0] P_S3 = {G, R, G, R};
    localparam logic [11:0] P_S4 = {Y, R, Y, R};
    localparam logic [11:0] P_S5 = {R, R, R, G};
    localparam logic [11:0] P_S6 = {R, R, R, Y};

    logic       clk;
    logic       rst;
    logic [2:0] a_m1, a_s, a_mt, a_m2;
    logic [2:0] b_m1, b_s, b_mt, b_m2;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl dut_a (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (a_m1),
        .light_S  (a_s),
        .light_MT (a_mt),
        .light_M2 (a_m2)
    );

    traffic_light_ctrl #(.T_MAIN(3), .T_SIDE(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .light_M1 (b_m1),
        .light_S  (b_s),
        .light_MT (b_mt),
        .light_M2 (b_m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default timing: boundaries at 7,9,14,16,19, period 21
    function automatic logic [11:0] exp_a(input int n);
        int p;
        p = n % 21;
        if (p < 7)  return P_S1;
        if (p < 9)  return P_S2;
        if (p < 14) return P_S3;
        if (p < 16) return P_S4;
        if (p < 19) return P_S5;
        return P_S6;
    endfunction

    // Override timing 3+2+5+2+1+2: boundaries at 3,5,10,12,13, period 15
    function automatic logic [11:0] exp_b(input int n);
        int p;
        p = n % 15;
        if (p < 3)  return P_S1;
        if (p < 5)  return P_S2;
        if (p < 10) return P_S3;
        if (p < 12) return P_S4;
        if (p < 13) return P_S5;
        return P_S6;
    endfunction

    function automatic logic is_lamp(input logic [2:0] v);
        return (v === R) || (v === Y) || (v === G);
    endfunction

    function automatic logic safe(input logic [2:0] m1, input logic [2:0] m2,
                                  input logic [2:0] mt, input logic [2:0] s);
        logic ok;
        ok = is_lamp(m1) && is_lamp(m2) && is_lamp(mt) && is_lamp(s);
        if (s !== R && (m1 !== R || m2 !== R || mt !== R)) ok = 1'b0;
        if (mt !== R && m2 !== R) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int n);
        check($sformatf("%s_a_n%0d", tag, n), {a_m1, a_m2, a_mt, a_s}, exp_a(n));
        check($sformatf("%s_b_n%0d", tag, n), {b_m1, b_m2, b_mt, b_s}, exp_b(n));
        check($sformatf("%s_safe_a_n%0d", tag, n), {11'b0, safe(a_m1, a_m2, a_mt, a_s)}, 12'd1);
        check($sformatf("%s_safe_b_n%0d", tag, n), {11'b0, safe(b_m1, b_m2, b_mt, b_s)}, 12'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        // Assert reset between posedges; S1 must appear before any clock edge
        #3 rst = 1'b0;
        #1;
        check("reset_async_a", {a_m1, a_m2, a_mt, a_s}, P_S1);
        check("reset_async_b", {b_m1, b_m2, b_mt, b_s}, P_S1);
        @(posedge clk);
        #2;
        check("reset_held_a", {a_m1, a_m2, a_mt, a_s}, P_S1);
        #3 rst = 1'b1;

        n = 0;
        check_all("run", n);
        for (int i = 0; i < 210; i++) begin
            @(posedge clk);
            #2;
            n++;
            check_all("run", n);
        end

        // Advance into the middle of S5, then reset asynchronously
        for (int i = 0; i < 21; i++) begin
            if ((n % 21) == 17) break;
            @(posedge clk);
            #2;
            n++;
        end
        check("pre_midreset_a", {a_m1, a_m2, a_mt, a_s}, P_S5);
        rst = 1'b0;
        #1;
        check("midreset_a", {a_m1, a_m2, a_mt, a_s}, P_S1);
        check("midreset_b", {b_m1, b_m2, b_mt, b_s}, P_S1);
        @(posedge clk);
        #2;
        check("midreset_held_a", {a_m1, a_m2, a_mt, a_s}, P_S1);
        #2 rst = 1'b1;

        n = 0;
        check_all("post", n);
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #2;
            n++;
            check_all("post", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
